// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle on magnitudes, sign fix-up at the end.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               zero_div_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign a_neg  = is_signed & src_a[WIDTH-1];
  assign b_neg  = is_signed & src_b[WIDTH-1];
  assign a_abs  = a_neg ? -src_a : src_a;
  assign b_abs  = b_neg ? -src_b : src_b;

  // acc_q holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV.
  always_comb begin
    acc_step = acc_q;
    mul_sum  = '0;
    div_diff = '0;
    if (is_div_q) begin
      div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
      if (!div_diff[WIDTH]) begin
        acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = neg_res_q ? -acc_q : acc_q;
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (is_div_q) begin
      // A zero divisor leaves HI/LO untouched, as on the real pipeline.
      if (zero_div_q) begin
        hi_fix = hi_q;
        lo_fix = lo_q;
      end else begin
        lo_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        hi_fix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = (accept && !op[1]) ? StCalc : StIdle;
      StCalc:         if (cnt_q == LastCnt) state_d = StFix;
      StFix:          state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      dbz_q      <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (op == OP_MTHI) begin
          hi_q <= src_a;
        end else if (op == OP_MTLO) begin
          lo_q <= src_a;
        end else begin
          is_div_q   <= (op == OP_DIV);
          neg_res_q  <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          zero_div_q <= (src_b == '0);
          dbz_q      <= 1'b0;
          cnt_q      <= '0;
          mcand_q    <= (op == OP_DIV) ? b_abs : a_abs;
          acc_q      <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? a_abs : b_abs)};
        end
      end
      if (state_q == StCalc) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CntW'(1);
      end
      if (state_q == StFix) begin
        hi_q  <= hi_fix;
        lo_q  <= lo_fix;
        dbz_q <= is_div_q & zero_div_q;
      end
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          is_signed = 1'b0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .is_signed   (is_signed),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // Reference arithmetic straight from the MIPS definitions.
  function automatic void model_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh,
                                   output logic [31:0] rl, output logic z);
    logic [63:0] p;
    z  = 1'b0;
    rh = '0;
    rl = '0;
    if (o == 2'b00) begin
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = {32'b0, a} * {32'b0, b};
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 0) begin
      z = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        rl = a;
        rh = '0;
      end else begin
        rl = $signed(a) / $signed(b);
        rh = $signed(a) % $signed(b);
      end
    end else begin
      rl = a / b;
      rh = a % b;
    end
  endfunction

  // m_age: 0 idle, 1..W+1 iterating, W+2 the done cycle.
  int          m_age = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dbz = 1'b0, p_dbz = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_age = 0;
      m_hi  = '0;
      m_lo  = '0;
      m_dbz = 1'b0;
    end else if (start && (m_age == 0 || m_age == W + 2)) begin
      if (op == 2'b10) begin
        m_hi  = src_a;
        m_age = 0;
      end else if (op == 2'b11) begin
        m_lo  = src_a;
        m_age = 0;
      end else begin
        model_op(op, is_signed, src_a, src_b, p_hi, p_lo, p_dbz);
        m_dbz = 1'b0;
        m_age = 1;
      end
    end else if (m_age == W + 2) begin
      m_age = 0;
    end else if (m_age != 0) begin
      m_age++;
      if (m_age == W + 2) begin
        if (!p_dbz) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
        m_dbz = p_dbz;
      end
    end
  end

  always @(negedge clk) begin
    chk1("model busy", busy, (m_age >= 1 && m_age <= W + 1));
    chk1("model done", done, (m_age == W + 2));
    chk32("model hi", hi, m_hi);
    chk32("model lo", lo, m_lo);
    chk1("model div_by_zero", div_by_zero, m_dbz);
  end

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] a,
                       input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    is_signed = s;
    src_a     = a;
    src_b     = b;
    acc_cyc   = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
    op        = 2'($urandom_range(0, 3));
    is_signed = 1'($urandom_range(0, 1));
    src_a     = $urandom;
    src_b     = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    busy_n = 0;
    while (!done && (cyc - acc_cyc) < 60) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic s,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] eh,
                     input logic [31:0] el, input logic ez);
    int lat, bn;
    issue(o, s, a, b);
    wait_done(lat, bn);
    chk32({name, " latency"}, 32'(lat), 32'd33);
    chk32({name, " hi"}, hi, eh);
    chk32({name, " lo"}, lo, el);
    chk1({name, " div_by_zero"}, div_by_zero, ez);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bn;
    bit saw_done;
    #1;
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk32("reset hi", hi, 32'h0);
    chk32("reset lo", lo, 32'h0);
    chk1("reset div_by_zero", div_by_zero, 1'b0);

    // Release and start on the very first edge after reset.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    chk32("umult max latency", 32'(lat), 32'd33);
    chk32("umult max busy cycles", 32'(bn), 32'd33);
    chk32("umult max hi", hi, 32'hFFFF_FFFE);
    chk32("umult max lo", lo, 32'h0000_0001);

    @(negedge clk);
    run("smult -3x5", 2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    @(negedge clk);
    run("umult 3x5", 2'b00, 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000_000F, 1'b0);
    @(negedge clk);
    run("sdiv -7/2", 2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    run("udiv 7/2", 2'b01, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    @(negedge clk);
    run("sdiv min/-1", 2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

    // MTHI/MTLO then divide by zero leaves HI/LO alone.
    @(negedge clk);
    issue(2'b10, 1'b0, 32'h11, 32'h0);
    chk1("mthi no busy", busy, 1'b0);
    chk32("mthi hi", hi, 32'h11);
    issue(2'b11, 1'b0, 32'h22, 32'h0);
    chk1("mtlo no done", done, 1'b0);
    chk32("mtlo lo", lo, 32'h22);
    run("div by zero", 2'b01, 1'b1, 32'd1234, 32'd0, 32'h11, 32'h22, 1'b1);
    repeat (3) @(negedge clk);
    chk1("div_by_zero sticky", div_by_zero, 1'b1);
    issue(2'b00, 1'b0, 32'd3, 32'd5);
    chk1("div_by_zero cleared on accept", div_by_zero, 1'b0);
    wait_done(lat, bn);
    chk32("mult after dbz lo", lo, 32'h0000_000F);
    chk1("mult after dbz flag", div_by_zero, 1'b0);

    // MTLO strobe mid-calculation must be ignored.
    @(negedge clk);
    issue(2'b00, 1'b1, 32'd7, 32'hFFFF_FFFE);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk32("ignored mtlo lo", lo, 32'h0000_000F);
    wait_done(lat, bn);
    chk32("ignored mtlo latency", 32'(lat), 32'd33);
    chk32("7x-2 hi", hi, 32'hFFFF_FFFF);
    chk32("7x-2 lo", lo, 32'hFFFF_FFF2);
    // Back-to-back: accepted in the DONE cycle.
    run("b2b udiv 100/7", 2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    issue(2'b00, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) @(negedge clk);
    chk1("busy before reset", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("midop reset busy", busy, 1'b0);
    chk1("midop reset done", done, 1'b0);
    chk32("midop reset hi", hi, 32'h0);
    chk32("midop reset lo", lo, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk1("no done after reset", saw_done, 1'b0);
    run("mult after reset", 2'b00, 1'b0, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request strobe, sampled on each rising clk edge.
REQ-005 The block SHALL have port op  input  2  operation: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 The block SHALL have port is_signed  input  1  two's-complement (1) or unsigned (0) for MULT/DIV.
REQ-007 The block SHALL have ports src_a, src_b  input  WIDTH  operands: multiplicand/dividend, multiplier/divisor; src_a is the MTHI/MTLO data.
REQ-008 The block SHALL have port busy  output  1  high while an operation is iterating.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse for MULT/DIV.
REQ-010 The block SHALL have ports hi, lo  output  WIDTH  HI/LO register contents.
REQ-011 The block SHALL have port div_by_zero  output  1  sticky flag for the last DIV having a zero divisor.

Function
REQ-012 The block SHALL implement states IDLE, CALC, FIX and DONE; busy=1 in CALC/FIX only, and done=1 in DONE only.
REQ-013 The block SHALL accept start only in IDLE or DONE; a start seen in CALC/FIX SHALL be ignored without side effects.
REQ-014 An accepted MTHI/MTLO SHALL write src_a into hi/lo at the accepting edge, enter IDLE, and assert neither busy nor done.
REQ-015 An accepted MULT/DIV SHALL latch op, is_signed and the operands (absolute values when is_signed=1), clear div_by_zero, zero the iteration counter and enter CALC; later operand changes SHALL have no effect.
REQ-016 CALC SHALL perform exactly one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle for WIDTH cycles, then enter FIX.
REQ-017 FIX SHALL apply sign correction and load hi/lo in one cycle, then enter DONE.
REQ-018 After FIX, the block SHALL enter DONE for one cycle and then return to IDLE unless a new start is accepted.
REQ-019 done SHALL assert exactly WIDTH+1 cycles after the accepting edge, with hi/lo already valid in that cycle.
REQ-020 MULT SHALL produce a 2*WIDTH product, with hi = upper half and lo = lower half, negated when is_signed=1 and the operand signs differ.
REQ-021 DIV SHALL produce lo = quotient and hi = remainder.
REQ-022 For signed DIV, the quotient SHALL be negated when the operand signs differ.
REQ-023 For signed DIV, the remainder SHALL take the sign of the dividend.
REQ-024 For signed DIV, the most-negative value divided by -1 SHALL yield lo = most-negative value and hi = 0, wrapping with no flag.
REQ-025 DIV with src_b = 0 SHALL keep the full latency, leave hi/lo unchanged, set div_by_zero, and hold div_by_zero until the next accepted MULT/DIV.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH per result half, with no overflow indication.

Reset
REQ-027 While rst=0, the block SHALL force state IDLE, counter 0, and busy, done, div_by_zero, hi and lo to 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-029 The block SHALL accept start again at the first rising edge after rst deasserts.

Structure
REQ-030 Package mips_muldiv_pkg SHALL hold the op encodings (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO) and the state enumeration.
REQ-031 The block SHALL be a single module with no sub-modules; the iteration counter width SHALL be derived from WIDTH inside the module.

Verification (WIDTH=32)
REQ-032 The bench SHALL check: unsigned MULT 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after the accepting edge, busy high for 32+1 cycles.
REQ-033 The bench SHALL check: signed MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; unsigned MULT 3 x 5 -> hi=0, lo=0x0000000F.
REQ-034 The bench SHALL check: signed DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned DIV 7 / 2 -> lo=3, hi=1; signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 The bench SHALL check: MTHI 0x11, MTLO 0x22, then DIV x / 0 -> hi=0x11, lo=0x22, div_by_zero=1 at done; a following MULT clears div_by_zero.
REQ-036 The bench SHALL check: start pulsed with op=MTLO during CALC -> lo unchanged and original result delivered on time; start accepted in the DONE cycle -> back-to-back operation with the next done 33 cycles later.
REQ-037 The bench SHALL check: rst driven low at cycle 10 of a MULT -> busy, done, hi, lo = 0 immediately, no done pulse afterwards, and a new MULT after release completes correctly.
